// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the fetch/data SRAM port arbiter.
//   arb_owner_e            : which requester owns the read response of the current cycle
//   DEFAULT_MAX_DATA_BURST : default number of back-to-back data grants allowed while fetch waits
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        OWNER_NONE  = 2'd0,
        OWNER_FETCH = 2'd1,
        OWNER_DATA  = 2'd2
    } arb_owner_e;

    localparam int unsigned DEFAULT_MAX_DATA_BURST = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Single-port SRAM bus with 1-cycle read latency.
//   master : enable, write_enable, address, write_data, byte_enable out; read_data in
//   slave  : the SRAM side of the same bus
interface MemoryInterfaceSinglePort
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    logic                  enable;
    logic                  write_enable;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] write_data;
    logic [BE_WIDTH-1:0]   byte_enable;
    logic [DATA_WIDTH-1:0] read_data;

    modport master (
        output enable, write_enable, address, write_data, byte_enable,
        input  read_data
    );

    modport slave (
        input  enable, write_enable, address, write_data, byte_enable,
        output read_data
    );

endinterface

// File: rtl/mem_port_arbiter_fairness.sv
// Counts consecutive data grants taken while fetch is waiting; saturates at MAX_COUNT.
// Only built when ARB_FAIRNESS_EN is defined.
//   clk, rst  : clock, synchronous active-high reset
//   inc       : a data grant was given while fetch was requesting
//   clr       : fetch was granted or is not requesting
//   saturated : count has reached MAX_COUNT, fetch must win the next contended cycle
`ifdef ARB_FAIRNESS_EN
module arb_fairness_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_COUNT = DEFAULT_MAX_DATA_BURST
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic saturated
);
    localparam int unsigned CNT_W = $clog2(MAX_COUNT + 1);

    logic [CNT_W-1:0] count_q;

    // Burst counter; clear wins over increment, holds once saturated.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && !saturated) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign saturated = (count_q == CNT_W'(MAX_COUNT));

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port SRAM.
// Data has priority; grants are combinational in the request cycle and the
// read response is routed one cycle later by a registered owner tag.
// Optional macro ARB_FAIRNESS_EN: after MAX_DATA_BURST data grants taken while
// fetch waits, fetch wins the next contended cycle.
//   clk, rst                          : clock, synchronous active-high reset
//   f_req/f_addr/f_gnt                : fetch read request, address, grant
//   f_rvalid/f_rdata                  : fetch read response
//   d_req/d_we/d_addr/d_wdata/d_be    : data request, write flag, address, data, byte enables
//   d_gnt/d_rvalid/d_rdata            : data grant and read response
//   sram                              : shared SRAM bus (master side)
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned MAX_DATA_BURST = DEFAULT_MAX_DATA_BURST
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    f_req,
    input  logic [ADDR_WIDTH-1:0]   f_addr,
    output logic                    f_gnt,
    output logic                    f_rvalid,
    output logic [DATA_WIDTH-1:0]   f_rdata,

    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_be,
    output logic                    d_gnt,
    output logic                    d_rvalid,
    output logic [DATA_WIDTH-1:0]   d_rdata,

    MemoryInterfaceSinglePort.master sram
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    if (MAX_DATA_BURST == 0) begin : g_bad_cfg
        $error("MAX_DATA_BURST must be at least 1");
    end

    arb_owner_e owner_q;
    arb_owner_e owner_d;
    logic       saturated;
    logic       fetch_wins;

`ifdef ARB_FAIRNESS_EN
    arb_fairness_counter #(
        .MAX_COUNT (MAX_DATA_BURST)
    ) u_fairness (
        .clk       (clk),
        .rst       (rst),
        .inc       (d_gnt && f_req),
        .clr       (f_gnt || !f_req),
        .saturated (saturated)
    );
`else
    assign saturated = 1'b0;
`endif

    // Grant selection and SRAM drive; idle bus parks at zero with all byte enables set.
    always_comb begin
        f_gnt             = 1'b0;
        d_gnt             = 1'b0;
        owner_d           = OWNER_NONE;
        sram.enable       = 1'b0;
        sram.write_enable = 1'b0;
        sram.address      = '0;
        sram.write_data   = '0;
        sram.byte_enable  = {BE_WIDTH{1'b1}};

        fetch_wins = f_req && (!d_req || saturated);

        if (!rst) begin
            if (fetch_wins) begin
                f_gnt        = 1'b1;
                owner_d      = OWNER_FETCH;
                sram.enable  = 1'b1;
                sram.address = f_addr;
            end else if (d_req) begin
                d_gnt             = 1'b1;
                owner_d           = d_we ? OWNER_NONE : OWNER_DATA;
                sram.enable       = 1'b1;
                sram.write_enable = d_we;
                sram.address      = d_addr;
                sram.write_data   = d_wdata;
                sram.byte_enable  = d_be;
            end
        end
    end

    // Owner of the read data arriving next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= OWNER_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // Gated by rst so a response in flight when reset asserts is dropped.
    assign f_rvalid = !rst && (owner_q == OWNER_FETCH);
    assign d_rvalid = !rst && (owner_q == OWNER_DATA);

    assign f_rdata = sram.read_data;
    assign d_rdata = sram.read_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned MAXB = 4;
`ifdef ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_gnt;
    logic          f_rvalid;
    logic [DW-1:0] f_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [3:0]    d_be;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;

    int n_cmp = 0;
    int n_err = 0;

    MemoryInterfaceSinglePort #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) sram ();

    mem_port_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .MAX_DATA_BURST (MAXB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .f_req    (f_req),
        .f_addr   (f_addr),
        .f_gnt    (f_gnt),
        .f_rvalid (f_rvalid),
        .f_rdata  (f_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_be     (d_be),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .sram     (sram.master)
    );

    always #5 clk = ~clk;

    // SRAM behaviour: 64 words, 1-cycle read latency, byte-masked writes.
    logic [31:0] sram_mem [64];
    always @(posedge clk) begin
        if (sram.enable) begin
            if (sram.write_enable) begin
                for (int b = 0; b < 4; b++)
                    if (sram.byte_enable[b])
                        sram_mem[sram.address[7:2]][b*8 +: 8] <= sram.write_data[b*8 +: 8];
            end else begin
                sram.read_data <= sram_mem[sram.address[7:2]];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: priority rules, burst count, who owns next cycle's read, expected memory.
    logic [31:0] ref_mem [64];
    int          burst     = 0;
    int          last_own  = 0;      // 0 none, 1 fetch read, 2 data read
    logic [31:0] last_data = '0;

    always @(negedge clk) begin
        bit fw, ef, ed, efv, edv;
        logic [31:0] ea;
        fw  = f_req && (!d_req || (FAIR && burst == int'(MAXB)));
        ef  = !rst && fw;
        ed  = !rst && d_req && !fw;
        efv = !rst && last_own == 1;
        edv = !rst && last_own == 2;
        ea  = ef ? f_addr : (ed ? d_addr : 32'h0);

        chk("f_gnt", 32'(f_gnt), 32'(ef));
        chk("d_gnt", 32'(d_gnt), 32'(ed));
        chk("f_rvalid", 32'(f_rvalid), 32'(efv));
        chk("d_rvalid", 32'(d_rvalid), 32'(edv));
        chk("sram_en", 32'(sram.enable), 32'(ef || ed));
        chk("sram_we", 32'(sram.write_enable), 32'(ed && d_we));
        chk("sram_addr", sram.address, ea);
        chk("sram_be", 32'(sram.byte_enable), ed ? 32'(d_be) : 32'hF);
        if (!ef) chk("sram_wdata", sram.write_data, ed ? d_wdata : 32'h0);
        if (efv) chk("f_rdata", f_rdata, last_data);
        if (edv) chk("d_rdata", d_rdata, last_data);

        if (ef) begin
            last_own  = 1;
            last_data = ref_mem[f_addr[7:2]];
        end else if (ed && !d_we) begin
            last_own  = 2;
            last_data = ref_mem[d_addr[7:2]];
        end else begin
            last_own = 0;
        end
        if (ed && d_we)
            for (int b = 0; b < 4; b++)
                if (d_be[b]) ref_mem[d_addr[7:2]][b*8 +: 8] = d_wdata[b*8 +: 8];

        if (rst || ef || !f_req) burst = 0;
        else if (ed) burst++;
    end

    task automatic drive(input logic r, input logic fr, input logic [31:0] fa,
                         input logic dr, input logic dwe, input logic [31:0] da,
                         input logic [31:0] dw, input logic [3:0] be);
        rst = r; f_req = fr; f_addr = fa;
        d_req = dr; d_we = dwe; d_addr = da; d_wdata = dw; d_be = be;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'hF);
    endtask

    initial begin
        int nf, nd;
        logic [4:0] pat;
        for (int i = 0; i < 64; i++) begin
            sram_mem[i] = 32'h1000_0000 + 32'(i);
            ref_mem[i]  = 32'h1000_0000 + 32'(i);
        end

        // Requests raised during reset are ignored.
        drive(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF);
        @(negedge clk);
        chk("rst_f_gnt", 32'(f_gnt), 32'h0);
        chk("rst_d_gnt", 32'(d_gnt), 32'h0);
        chk("rst_en", 32'(sram.enable), 32'h0);
        step();

        idle();
        @(negedge clk);
        chk("idle_en", 32'(sram.enable), 32'h0);
        chk("idle_be", 32'(sram.byte_enable), 32'hF);
        step();

        // Lone fetch read of 0x10.
        drive(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'hF);
        @(negedge clk);
        chk("fetch_gnt", 32'(f_gnt), 32'h1);
        step();
        idle();
        @(negedge clk);
        chk("fetch_rvalid", 32'(f_rvalid), 32'h1);
        chk("fetch_rdata", f_rdata, 32'h1000_0004);
        step();

        // Data write contends with fetch; data wins, fetch follows.
        drive(1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF, 4'b0011);
        @(negedge clk);
        chk("wr_d_gnt", 32'(d_gnt), 32'h1);
        chk("wr_f_gnt", 32'(f_gnt), 32'h0);
        chk("wr_we", 32'(sram.write_enable), 32'h1);
        step();
        drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'hF);
        @(negedge clk);
        chk("wr_no_drv", 32'(d_rvalid), 32'h0);
        chk("wr_no_frv", 32'(f_rvalid), 32'h0);
        chk("wr_then_f_gnt", 32'(f_gnt), 32'h1);
        step();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
        @(negedge clk);
        chk("f0_rdata", f_rdata, 32'h1000_0000);
        step();
        idle();
        @(negedge clk);
        chk("readback_drv", 32'(d_rvalid), 32'h1);
        chk("readback", d_rdata, 32'h1000_BEEF);
        step();

        // Alternating fetch 0x0 / data 0x4.
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'hF);
            @(negedge clk);
            if (k > 0) chk("alt_d_rdata", d_rdata, 32'h1000_0001);
            step();
            drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF);
            @(negedge clk);
            chk("alt_f_rvalid", 32'(f_rvalid), 32'h1);
            chk("alt_f_rdata", f_rdata, 32'h1000_0000);
            step();
        end
        idle();
        @(negedge clk);
        chk("alt_last_drv", 32'(d_rvalid), 32'h1);
        step();

        // Both requesters held high.
        nf = 0; nd = 0;
        drive(1'b0, 1'b1, 32'hC, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            nf += int'(f_gnt);
            nd += int'(d_gnt);
            if (i % 5 == 4) chk("burst_slot_f_gnt", 32'(f_gnt), 32'(FAIR));
            step();
        end
        chk("burst_f_count", 32'(nf), FAIR ? 32'd3 : 32'd0);
        chk("burst_d_count", 32'(nd), FAIR ? 32'd12 : 32'd15);

        // Build up a partial burst, then reset in the cycle a data read would be granted.
        step();
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_cycle_d_gnt", 32'(d_gnt), 32'h0);
        chk("rst_cycle_drv", 32'(d_rvalid), 32'h0);
        step();
        rst = 1'b0;
        pat = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) chk("post_rst_drv", 32'(d_rvalid), 32'h0);
            pat[i] = f_gnt;
            step();
        end
        chk("post_rst_pattern", 32'(pat), FAIR ? 32'h10 : 32'h0);

        idle();
        step();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
